// File: rtl/ie_fetch_predecode.sv
// Fetch/predecode stage: reads opcode plus 0-2 operand bytes over a byte bus
// and presents one decoded-length instruction bundle per valid/ready handshake.
module ie_fetch_predecode #(
  parameter logic [15:0] RESET_PC = 16'h8000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_gnt,
  input  logic [7:0]  mem_rdata,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_opcode,
  output logic [15:0] out_operand,
  output logic [1:0]  out_len,
  output logic        out_immediate,
  output logic [15:0] out_pc,
  output logic [15:0] out_pc_next
);

  typedef enum logic [2:0] {
    S_OP_REQ,
    S_OP_DAT,
    S_LO_REQ,
    S_LO_DAT,
    S_HI_REQ,
    S_HI_DAT,
    S_OUT
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] pc;
  logic [15:0] op_pc;
  logic [7:0]  op_q;
  logic [7:0]  lo_q;
  logic [1:0]  len_q;
  logic        is_req;
  logic        gnt;
  logic        load_bundle;
  logic [7:0]  b_opcode;
  logic [15:0] b_operand;
  logic [1:0]  b_len;
  logic        b_imm;
  logic [15:0] b_pc;

  function automatic logic [1:0] inst_len(input logic [7:0] op);
    if (op == 8'h20 || op[3:2] == 2'b11 || op[4:0] == 5'b11001)
      return 2'd3;
    else if (op == 8'h00 || op == 8'h40 || op == 8'h60 ||
             op[3:0] == 4'h8 || op[3:0] == 4'hA)
      return 2'd1;
    else
      return 2'd2;
  endfunction

  function automatic logic is_imm(input logic [7:0] op);
    return (op[4:0] == 5'b01001) || (op == 8'hA0) || (op == 8'hA2) ||
           (op == 8'hC0) || (op == 8'hE0);
  endfunction

  // Request is masked while rst is held so no grant can be taken during reset.
  assign is_req    = (state == S_OP_REQ) || (state == S_LO_REQ) || (state == S_HI_REQ);
  assign mem_rd    = is_req && !rst;
  assign mem_addr  = pc;
  assign gnt       = mem_rd && mem_gnt;
  assign out_valid = (state == S_OUT);

  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      state_nxt = S_OP_REQ;
    end else begin
      case (state)
        S_OP_REQ: if (gnt) state_nxt = S_OP_DAT;
        S_OP_DAT: state_nxt = (inst_len(mem_rdata) == 2'd1) ? S_OUT : S_LO_REQ;
        S_LO_REQ: if (gnt) state_nxt = S_LO_DAT;
        S_LO_DAT: state_nxt = (len_q == 2'd2) ? S_OUT : S_HI_REQ;
        S_HI_REQ: if (gnt) state_nxt = S_HI_DAT;
        S_HI_DAT: state_nxt = S_OUT;
        S_OUT:    if (out_ready) state_nxt = S_OP_REQ;
        default:  state_nxt = S_OP_REQ;
      endcase
    end
  end

  // Bundle assembly; pc already points past the last fetched byte here.
  always_comb begin
    b_opcode  = op_q;
    b_operand = 16'h0000;
    b_len     = len_q;
    b_imm     = is_imm(op_q);
    b_pc      = op_pc;
    case (state)
      S_OP_DAT: begin
        b_opcode = mem_rdata;
        b_len    = inst_len(mem_rdata);
        b_imm    = is_imm(mem_rdata);
        b_pc     = pc - 16'd1;
      end
      S_LO_DAT: b_operand = {8'h00, mem_rdata};
      S_HI_DAT: b_operand = {mem_rdata, lo_q};
      default:  b_operand = 16'h0000;
    endcase
    load_bundle = (state != S_OUT) && (state_nxt == S_OUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_OP_REQ;
      pc            <= RESET_PC;
      op_pc         <= 16'h0000;
      op_q          <= 8'h00;
      lo_q          <= 8'h00;
      len_q         <= 2'd0;
      out_opcode    <= 8'h00;
      out_operand   <= 16'h0000;
      out_len       <= 2'd0;
      out_immediate <= 1'b0;
      out_pc        <= 16'h0000;
      out_pc_next   <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (redirect_valid)
        pc <= redirect_pc;
      else if (gnt)
        pc <= pc + 16'd1;
      if (state == S_OP_DAT) begin
        op_q  <= mem_rdata;
        op_pc <= pc - 16'd1;
        len_q <= inst_len(mem_rdata);
      end
      if (state == S_LO_DAT)
        lo_q <= mem_rdata;
      if (load_bundle) begin
        out_opcode    <= b_opcode;
        out_operand   <= b_operand;
        out_len       <= b_len;
        out_immediate <= b_imm;
        out_pc        <= b_pc;
        out_pc_next   <= pc;
      end
    end
  end

endmodule

// File: doc/ie_fetch_predecode.md
Name: ie_fetch_predecode

Overview:
- Fetch/predecode stage directly upstream of the IE simple-op decoder.
- Reads the opcode byte and 0-2 operand bytes at the current PC over a single-port byte memory bus.
- Determines instruction length and the immediate flag, then presents one instruction bundle per valid/ready handshake.
- The opcode-to-flag table that produces simple_op, store/load and ALU flags is combinational and lives downstream of this bundle.

Parameters:
RESET_PC, 16'h8000, PC loaded on reset.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
mem_addr  out  16  byte address of current read request
mem_rd  out  1  read request; held high until granted
mem_gnt  in  1  request accepted this cycle (mem_rd & mem_gnt)
mem_rdata  in  8  read data, valid exactly one cycle after grant
redirect_valid  in  1  branch/jump/interrupt redirect, one-cycle pulse
redirect_pc  in  16  new PC, sampled when redirect_valid=1
out_valid  out  1  bundle valid
out_ready  in  1  downstream accepts bundle
out_opcode  out  8  raw opcode byte
out_operand  out  16  {hi,lo} operand; unused bytes are 0
out_len  out  2  instruction length in bytes, 1..3
out_immediate  out  1  immediate addressing mode
out_pc  out  16  address of opcode byte
out_pc_next  out  16  out_pc + out_len, mod 2^16

Behaviour:
- Reset (rst=1 at edge):
  - state=S_OP_REQ, pc=RESET_PC.
  - Registered outputs: out_valid=0, mem_rd=0, all bundle fields 0.
  - mem_addr=RESET_PC.
  - rst overrides everything, including a transfer in flight; grant data returning after reset is ignored.
- States: S_OP_REQ, S_OP_DAT, S_LO_REQ, S_LO_DAT, S_HI_REQ, S_HI_DAT, S_OUT.
- Every *_REQ state: mem_rd=1, mem_addr=pc. On mem_gnt, pc<=pc+1 (16-bit wrap, FFFF->0000) and go to the matching *_DAT state. Without mem_gnt, stay; mem_addr stays stable.
- Every *_DAT state: mem_rd=0; capture mem_rdata.
  - S_OP_DAT: opcode<=data, op_pc<=pc-1. Compute len.
    - len=1 -> S_OUT.
    - else -> S_LO_REQ.
  - S_LO_DAT: lo<=data.
    - len=2 -> S_OUT.
    - else -> S_HI_REQ.
  - S_HI_DAT: hi<=data -> S_OUT.
- Length rule, first match wins:
  - 3 if opcode==8'h20, or opcode[3:2]==2'b11, or opcode[4:0]==5'b11001.
  - 1 if opcode in {00,40,60}, or opcode[3:0]==4'h8, or opcode[3:0]==4'hA.
  - 2 otherwise.
- Immediate rule: out_immediate=1 iff opcode[4:0]==5'b01001 or opcode in {A0,A2,C0,E0}.
- S_OUT: out_valid=1 and all bundle fields stable. On out_valid&out_ready, out_valid<=0 next cycle and state -> S_OP_REQ. pc already equals out_pc_next.
- Minimum latency with mem_gnt tied high, counted from entering S_OP_REQ to out_valid=1:
  - 1-byte: 2 cycles.
  - 2-byte: 4 cycles.
  - 3-byte: 6 cycles.
- Throughput: the bundle is not pipelined; the next fetch starts the cycle after the handshake.
- Redirect: redirect_valid=1 in any state -> next cycle pc<=redirect_pc, state=S_OP_REQ, out_valid=0, partial bytes dropped.
  - Data returning for a grant issued in the redirect cycle is discarded, because S_OP_REQ never captures.
  - Redirect coincident with out_valid&out_ready: the transfer counts as completed and the redirect also applies.
  - Redirect coincident with a grant: the grant is consumed, its data discarded.
- Operand formatting:
  - 1-byte instruction: operand=16'h0000.
  - 2-byte instruction: operand={8'h00,lo}.
- PC wrap applies inside an instruction too. Example: a 3-byte instruction at FFFE fetches FFFE, FFFF, 0000; pc_next=0001.

Test Plan:
1. Reset with RESET_PC=8000, mem_gnt=1. Memory holds 8000:A9 8001:42 -> mem_addr 8000 then 8001. Bundle: opcode=A9, operand=0042, len=2, immediate=1, pc=8000, pc_next=8002. out_valid is asserted 4 cycles after reset release.
2. Memory 8000:4C 8001:34 8002:12, with out_ready held low for 5 cycles -> bundle operand=1234, len=3, immediate=0. Bundle stays stable while waiting; no mem_rd until the handshake, then mem_addr=8003.
3. Memory 8000:E8 (INX), 8001:60 (RTS), out_ready=1 -> two bundles, len=1, operand=0000, pc=8000 then 8001. out_valid rises 2 cycles after each S_OP_REQ entry.
4. mem_gnt low for 3 cycles during the operand-lo request of AD 00 30 -> mem_addr held at 8001 and mem_rd stays high. The final bundle is unaffected: operand=3000.
5. redirect_valid with redirect_pc=C000, asserted in S_LO_DAT of a 3-byte fetch -> no bundle emitted; next mem_addr=C000. A later bundle carries pc=C000.
6. Redirect to FFFE where FFFE:20 FFFF:EF 0000:BE -> operand=BEEF, len=3, pc_next=0001. Then assert rst during S_HI_REQ -> out_valid=0, next mem_addr=RESET_PC.
